// File: rtl/axum_ctx_xfer.sv
// Context copy engine: moves NumWords register-context words from a source window
// to a destination window, one read then one write per word, one transaction outstanding.
module axum_ctx_xfer #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int NumWords     = 31,
    parameter int FirstReg     = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [AddressWidth-1:0]   src_base_i,
    input  logic [AddressWidth-1:0]   dst_base_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      m_req_o,
    input  logic                      m_gnt_i,
    output logic [AddressWidth-1:0]   m_addr_o,
    output logic                      m_we_o,
    output logic [DataWidth/8-1:0]    m_be_o,
    output logic [DataWidth-1:0]      m_wdata_o,
    input  logic                      m_rvalid_i,
    input  logic [DataWidth-1:0]      m_rdata_i,
    input  logic                      m_err_i
);

    localparam int KW = (NumWords > 1) ? $clog2(NumWords) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

    state_e                    r_state;
    logic [KW-1:0]             r_k;
    logic [AddressWidth-1:0]   r_src;
    logic [AddressWidth-1:0]   r_dst;
    logic [AddressWidth-1:0]   r_addr;
    logic                      r_we;
    logic [DataWidth-1:0]      r_data;
    logic                      r_done;
    logic                      r_err;
    logic [KW-1:0]             w_k_next;
    logic                      w_last;

    // Byte offset of word k inside a window; wraps modulo 2^AddressWidth.
    function automatic logic [AddressWidth-1:0] word_off(input logic [KW-1:0] k);
        logic [AddressWidth-1:0] idx;
        idx = AddressWidth'(FirstReg) + AddressWidth'(k);
        return idx << 2;
    endfunction

    assign w_k_next = r_k + KW'(1);
    assign w_last   = (r_k == KW'(NumWords - 1));

    // Handshake: a request is accepted on a cycle where m_req_o and m_gnt_i are both
    // high; its single response is the next cycle with m_rvalid_i high (m_err_i qualifies it).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_src   <= src_base_i;
                        r_dst   <= dst_base_i;
                        r_k     <= '0;
                        r_err   <= 1'b0;
                        r_addr  <= src_base_i + word_off('0);
                        r_we    <= 1'b0;
                        r_state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (m_gnt_i) r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (m_rvalid_i) begin
                        if (m_err_i) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_data  <= m_rdata_i;
                            r_addr  <= r_dst + word_off(r_k);
                            r_we    <= 1'b1;
                            r_state <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (m_gnt_i) r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (m_rvalid_i) begin
                        if (m_err_i) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_k     <= w_k_next;
                            r_addr  <= r_src + word_off(w_k_next);
                            r_we    <= 1'b0;
                            r_state <= RD_REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Request and busy decode from state alone so reset removes them at once.
    assign m_req_o   = (r_state == RD_REQ) || (r_state == WR_REQ);
    assign busy_o    = (r_state != IDLE);
    assign m_addr_o  = r_addr;
    assign m_we_o    = r_we;
    assign m_wdata_o = r_data;
    assign m_be_o    = '1;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_axum_ctx_xfer.sv
// Directed bench for axum_ctx_xfer: a bus responder model, an expected-transaction
// queue filled at each start, and a monitor that pops on every accepted request.
module tb_axum_ctx_xfer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] src_base_i;
  logic [31:0] dst_base_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        m_req_o;
  logic        m_gnt_i;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_wdata_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        m_err_i;

  axum_ctx_xfer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start_i),
    .src_base_i (src_base_i),
    .dst_base_i (dst_base_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .m_req_o    (m_req_o),
    .m_gnt_i    (m_gnt_i),
    .m_addr_o   (m_addr_o),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_wdata_o  (m_wdata_o),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i),
    .m_err_i    (m_err_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // {we, addr, wdata}
  logic [64:0] exp_q[$];

  logic [31:0] mem_base = 32'h0;
  int          stall_cnt = 0;
  int          err_on_wr = 0;
  int          wr_seen = 0;
  logic        pend = 1'b0;
  logic        p_we = 1'b0;
  logic [31:0] p_addr = 32'h0;

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Responder: grants (with optional stall), answers one cycle after the grant.
  initial begin
    m_gnt_i    = 1'b1;
    m_rvalid_i = 1'b0;
    m_rdata_i  = 32'h0;
    m_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      m_rvalid_i = 1'b0;
      m_err_i    = 1'b0;
      m_rdata_i  = 32'h0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        m_rvalid_i = 1'b1;
        if (!p_we) begin
          m_rdata_i = 32'hA000_0000 + ((p_addr - mem_base) >> 2);
        end else begin
          wr_seen++;
          if (wr_seen == err_on_wr) m_err_i = 1'b1;
        end
        pend = 1'b0;
      end
      if (m_req_o && stall_cnt > 0) begin
        m_gnt_i = 1'b0;
        stall_cnt--;
      end else begin
        m_gnt_i = 1'b1;
      end
      if (rst_n && m_req_o && m_gnt_i) begin
        pend   = 1'b1;
        p_we   = m_we_o;
        p_addr = m_addr_o;
      end
    end
  end

  // Monitor: every presented request is compared against the queue head;
  // the head is popped once the request is granted.
  initial forever begin
    logic [64:0] e;
    @(negedge clk);
    #1;
    if (rst_n && m_req_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=we%0b@%0h required=no_request", m_we_o, m_addr_o);
      end else begin
        e = exp_q[0];
        chk("req_we", {63'd0, m_we_o}, {63'd0, e[64]});
        chk("req_addr", {32'd0, m_addr_o}, {32'd0, e[63:32]});
        if (e[64]) chk("req_wdata", {32'd0, m_wdata_o}, {32'd0, e[31:0]});
        if (m_gnt_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = s + 32'(4 * (k + 1));
      exp_q.push_back({1'b0, a, 32'h0});
      a = d + 32'(4 * (k + 1));
      exp_q.push_back({1'b1, a, 32'hA000_0000 + 32'(k + 1)});
    end
  endtask

  // Called at a negedge: that cycle is cycle 0 of the new transfer.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
    start_i    = 1'b1;
    src_base_i = s;
    dst_base_i = d;
    mem_base   = s;
    wr_seen    = 0;
    t0         = cyc;
    push_xfer(s, d, n);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_cycle1", {63'd0, busy_o}, 64'd1);
    chk("err_cleared", {63'd0, err_o}, 64'd0);
  endtask

  task automatic wait_done(input int exp_lat, input logic exp_err, input string nm);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_done required=done_at_%0d", nm, exp_lat);
    end else begin
      chk(nm, 64'(lat), 64'(exp_lat));
      chk("busy_at_done", {63'd0, busy_o}, 64'd0);
      chk("err_at_done", {63'd0, err_o}, {63'd0, exp_err});
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    bit hit;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    src_base_i = 32'h0;
    dst_base_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, m_req_o}, 64'd0);
    chk("rst_we", {63'd0, m_we_o}, 64'd0);
    chk("rst_addr", {32'd0, m_addr_o}, 64'd0);
    chk("rst_wdata", {32'd0, m_wdata_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("be_ones", {60'd0, m_be_o}, 64'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-stall copy
    do_start(32'h1000, 32'h2000, 31);
    wait_done(125, 1'b0, "zero_stall_done");

    // grant stall on first read
    @(negedge clk);
    stall_cnt = 3;
    do_start(32'h1000, 32'h2000, 31);
    wait_done(128, 1'b0, "gnt_stall_done");

    // error on the write response of k=5
    @(negedge clk);
    err_on_wr = 6;
    do_start(32'h1000, 32'h2000, 6);
    wait_done(25, 1'b1, "abort_done");
    repeat (5) @(negedge clk);
    chk("err_sticky", {63'd0, err_o}, 64'd1);
    chk("abort_idle_req", {63'd0, m_req_o}, 64'd0);
    err_on_wr = 0;

    // start while busy is ignored; start in the done cycle is accepted
    do_start(32'h1000, 32'h2000, 31);
    while (cyc - t0 < 50) @(negedge clk);
    start_i    = 1'b1;
    src_base_i = 32'h5000;
    dst_base_i = 32'h6000;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(125, 1'b0, "collision_done");
    do_start(32'h1000, 32'h2000, 31);
    wait_done(125, 1'b0, "done_cycle_start_done");

    // reset during the read request of k=10
    @(negedge clk);
    do_start(32'h1000, 32'h2000, 31);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (m_req_o && !m_we_o && m_addr_o == 32'h102C) hit = 1'b1;
    end
    chk("reach_k10_read", {63'd0, hit}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {63'd0, m_req_o}, 64'd0);
    chk("async_rst_busy", {63'd0, busy_o}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_mid_addr", {32'd0, m_addr_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(32'h1000, 32'h2000, 31);
    wait_done(125, 1'b0, "after_reset_done");

    // address wrap-around
    @(negedge clk);
    do_start(32'hFFFF_FFF0, 32'h3000, 31);
    wait_done(125, 1'b0, "wrap_done");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axum_ctx_xfer.md
# axum_ctx_xfer

Bus-initiator engine that copies a block of register-context words from one address window to another over a single word-wide request/response port. It drives the memory-mapped port of the multi-context register file, saving an inactive context to memory or restoring one from memory without core involvement. It sits beside the register file on the system interconnect and is started by a single-cycle command from the context-switch control logic.

## Interface

- `DataWidth`, default 32: bus data width.
- `AddressWidth`, default 32: bus address width.
- `NumWords`, default 31: number of words copied per transfer. Use 15 for RV32E.
- `FirstReg`, default 1: index of the first word copied; x0 is skipped.

Ports:

- `clk_i`  in  1  clock. One clock domain only.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start pulse; accepted only in IDLE.
- `src_base_i`  in  AddressWidth  source window base; latched when start is accepted.
- `dst_base_i`  in  AddressWidth  destination window base; latched when start is accepted.
- `busy_o`  out  1  a transfer is in progress.
- `done_o`  out  1  one-cycle pulse at the end of a transfer, whether it completed or aborted.
- `err_o`  out  1  sticky abort flag; cleared when the next start is accepted.
- `m_req_o`  out  1  bus request.
- `m_gnt_i`  in  1  bus grant. Tie to 1 for a responder that always accepts.
- `m_addr_o`  out  AddressWidth  byte address of the request.
- `m_we_o`  out  1  1 = write, 0 = read.
- `m_be_o`  out  DataWidth/8  byte enables; constant all ones.
- `m_wdata_o`  out  DataWidth  write data.
- `m_rvalid_i`  in  1  response valid.
- `m_rdata_i`  in  DataWidth  read data.
- `m_err_i`  in  1  response error; qualified by `m_rvalid_i`.

## Operation

- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT. Word index `k` runs from 0 to NumWords-1.
- IDLE: when `start_i` is high, latch both bases, set k=0, clear `err_o`, and go to RD_REQ.
- RD_REQ: `m_req_o`=1, `m_we_o`=0, `m_addr_o` = src_base + (FirstReg+k)*4. When `m_gnt_i` is high, go to RD_WAIT.
- RD_WAIT: `m_req_o`=0. On `m_rvalid_i`:
  - If `m_err_i` is high, abort.
  - Otherwise capture `m_rdata_i` into the data register and go to WR_REQ.
- WR_REQ: `m_req_o`=1, `m_we_o`=1, `m_addr_o` = dst_base + (FirstReg+k)*4, `m_wdata_o` = captured data. When `m_gnt_i` is high, go to WR_WAIT.
- WR_WAIT: on `m_rvalid_i`:
  - If `m_err_i` is high, abort.
  - Else if k = NumWords-1, finish.
  - Otherwise increment k and go to RD_REQ.
- Finish: go to IDLE and pulse `done_o`.
- Abort: go to IDLE, pulse `done_o`, set `err_o`. No further requests are issued.
- At most one transaction is outstanding at any time.
- Address arithmetic is modulo 2^AddressWidth; wrap-around is legal and silent.
- Start handling:
  - `start_i` while busy is ignored, with no effect on the current transfer.
  - A start in the `done_o` cycle is accepted, because the state is already IDLE.
- `m_rvalid_i` outside RD_WAIT/WR_WAIT is ignored.
- Integration rule: when the source window is the register file's mapped port, it must not be the active context. The register file returns zero for that context, and the engine copies whatever it reads.

## Timing

- Reset values: `m_req_o`=0, `m_we_o`=0, `m_addr_o`=0, `m_wdata_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, state IDLE. `m_be_o` is all ones at all times.
- Reset is asynchronous. Asserting `rst_ni` mid-transfer drops `m_req_o` immediately and discards progress. A later start restarts from k=0.
- All outputs are registered or decoded from state only. There are no combinational paths from bus inputs to bus outputs.
- While `m_req_o`=1 and `m_gnt_i`=0, `m_addr_o`, `m_we_o` and `m_wdata_o` hold stable.
- Cycle-level schedule:
  - `start_i` is sampled in cycle 0.
  - `busy_o`=1 from cycle 1.
  - With a zero-stall responder (gnt=1, rvalid exactly one cycle after gnt), each word takes 4 cycles: read request at cycle 1+4k, read rvalid at 2+4k, write request at 3+4k, write rvalid at 4+4k.
  - `done_o`=1 and `busy_o`=0 at cycle 4·NumWords+1, which is 125 for the defaults.
- Each stall cycle on `m_gnt_i` or `m_rvalid_i` adds exactly one cycle.

## Test plan

- **Zero-stall copy.** Source word at 0x1000+4i = 0xA0000000+i; start with src=0x1000, dst=0x2000. Required: 31 reads at 0x1004..0x107C and 31 writes at 0x2004..0x207C carrying 0xA0000001..0xA000001F. `done_o` at cycle 125; `err_o`=0.
- **Grant stall.** Hold `m_gnt_i`=0 for 3 cycles on the first read. Required: `m_req_o`, `m_addr_o`=0x1004 and `m_we_o`=0 stable throughout the stall; `done_o` at cycle 128.
- **Error abort.** Assert `m_err_i` with the write rvalid of k=5. Required: words k=0..5 written, no further `m_req_o`, `done_o` pulse, `err_o`=1 held. A next start clears `err_o`.
- **Start collisions.** Pulse `start_i` at cycle 50 with a different src. Required: ignored, addresses unchanged. Pulse `start_i` in the `done_o` cycle. Required: new transfer begins, first read one cycle later.
- **Reset mid-transfer.** Assert `rst_ni` low during the RD_REQ of k=10. Required: `m_req_o`=0 and `busy_o`=0 asynchronously. After release, a start yields a first read at src+4.
- **Wrap-around.** src=0xFFFFFFF0. Required: k=0..2 read at 0xFFFFFFF4..0xFFFFFFFC, k=3 at 0x00000000, k=30 at 0x0000006C.
